change_dispenser: RTL
=====================

# change_dispenser

Computes and pays out change for a vending transaction. On a start pulse it takes the accumulated credit and the selected item's price and checks for sufficient funds. It then dispenses the difference as a greedy sequence of coins over a valid/ready handshake to the coin-ejector driver. It sits between the item-price lookup / credit accumulator and the ejector, and reports completion or insufficient funds to the vending control FSM.

## Interface
- `CREDIT_W`, default 9: width of the credit, cost and change values in cents (max 511).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `credit`  in  CREDIT_W  inserted credit in cents; sampled with `start`.
- `cost`  in  CREDIT_W  item price in cents; sampled with `start`.
- `coin_ready`  in  1  ejector accepts the presented coin this cycle.
- `coin_valid`  out  1  a coin is presented on `coin_type`.
- `coin_type`  out  2  coin code: 0 quarter (25), 1 dime (10), 2 nickel (5), 3 dollar (100, macro-gated).
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse: transaction finished and all change paid.
- `insufficient`  out  1  one-cycle pulse: credit < cost; nothing dispensed.
- `change_total`  out  CREDIT_W  credit − cost of the last successful transaction; held until the next start.

## Operation
- States: IDLE, DISPENSE, DONE, ERROR.
- IDLE, `start`=1:
  - compute `credit − cost` at CREDIT_W+1 bits.
  - borrow → ERROR.
  - otherwise latch the difference into `remaining` and `change_total`.
  - `remaining` ≥ 5 → DISPENSE; else → DONE.
- DISPENSE:
  - `coin_valid`=1.
  - `coin_type` is the greedy pick from `remaining`: ≥25 quarter, else ≥10 dime, else nickel.
  - On `coin_valid & coin_ready`, subtract the coin value from `remaining`.
  - After the subtraction, `remaining` < 5 → DONE; else stay in DISPENSE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- ERROR: `insufficient`=1 for exactly one cycle → IDLE. `change_total` is not updated.
- Residue below 5 cents, e.g. 3 cents from an odd credit, is dropped silently. `change_total` still reports the full difference.
- `start` while busy: ignored, not queued.
- `credit`/`cost` changing while busy: no effect.

## Timing
- Reset values:
  - state IDLE; `remaining` 0; `change_total` 0.
  - `coin_valid`, `done`, `insufficient` and `busy` all 0; `coin_type` 0.
  - Reset takes effect immediately, including mid-DISPENSE. An un-acknowledged coin is abandoned and no `done` is issued.
- `coin_valid`/`coin_type` decode from registered state and `remaining` only; no combinational path from `coin_ready`.
- Latency, counted from the cycle `start` is sampled:
  - first `coin_valid` the next cycle;
  - `insufficient`, or `done` for zero change, the next cycle.
- Back-to-back coins: with `coin_ready` held high, one coin per cycle and `coin_valid` stays high.
- `done` is asserted the cycle after the final handshake.
- Backpressure: while `coin_ready`=0, `coin_valid` and `coin_type` are held stable.
- `busy` is high from the cycle after `start` through the DONE/ERROR cycle inclusive.

## Configuration
- `CHANGE_DOLLAR_COIN_EN` defined:
  - greedy pick checks ≥100 first and emits `coin_type`=3 (dollar).
- Not defined:
  - code 3 is never generated; amounts of 100 and above are paid in quarters.

## Structure
- Shared package `vend_pkg`:
  - coin codes COIN_QUARTER/COIN_DIME/COIN_NICKEL/COIN_DOLLAR;
  - coin values 25/10/5/100;
  - CREDIT_W default;
  - FSM state encoding.
- Sub-module `coin_select`: combinational greedy pick taking `remaining` and returning coin code and value. The dollar branch is gated by the macro.
- Top: FSM, subtractor, `remaining`/`change_total` registers.

## Test plan
- credit=200, cost=125, `coin_ready`=1 → three quarters on consecutive cycles; `done` 1 cycle after the third; `change_total`=75.
- credit=100, cost=85 → dime then nickel; `done`; `change_total`=15.
- credit=50, cost=150 → `insufficient` pulse the cycle after start; `coin_valid` never high; `busy` high 1 cycle; `change_total` unchanged.
- credit=185, cost=185 → `done` the cycle after start; no coins. Same for credit=103, cost=100: 3-cent residue dropped, `change_total`=3.
- credit=150, cost=85 → Q,Q,D,N. Hold `coin_ready` low 3 cycles on the first coin: `coin_valid`/`coin_type` stable. `start` pulses mid-dispense are ignored. Assert `rst` during the 3rd coin: all outputs 0 immediately, no `done`.
- With `CHANGE_DOLLAR_COIN_EN`, credit=400, cost=50 → $,$,$,Q,Q; without the macro → fourteen quarters.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions for the change dispenser.
// Provides the coin codes, coin values in cents, the default credit
// width and the change-dispenser FSM state encoding.
// Optional feature macro used by the dispenser: CHANGE_DOLLAR_COIN_EN.
package vend_pkg;

  localparam int CREDIT_W_DEF = 9;

  typedef enum logic [1:0] {
    COIN_QUARTER = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_NICKEL  = 2'd2,
    COIN_DOLLAR  = 2'd3
  } coin_t;

  localparam int COIN_VAL_QUARTER = 25;
  localparam int COIN_VAL_DIME    = 10;
  localparam int COIN_VAL_NICKEL  = 5;
  localparam int COIN_VAL_DOLLAR  = 100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Bus bundle between the vending controller / ejector driver and the
// change dispenser.
//   start, credit, cost      : transaction request (controller -> dispenser)
//   coin_valid/type/ready    : coin handshake with the ejector driver
//   busy, done, insufficient : status back to the controller
//   change_total             : difference of the last paid transaction
// Modports: slave = dispenser side, master = controller/ejector side.
interface change_dispenser_if #(
  parameter int CREDIT_W = vend_pkg::CREDIT_W_DEF
) ();

  logic                start;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] cost;
  logic                coin_ready;
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                busy;
  logic                done;
  logic                insufficient;
  logic [CREDIT_W-1:0] change_total;

  modport slave (
    input  start, credit, cost, coin_ready,
    output coin_valid, coin_type, busy, done, insufficient, change_total
  );

  modport master (
    output start, credit, cost, coin_ready,
    input  coin_valid, coin_type, busy, done, insufficient, change_total
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// coin_select: combinational greedy coin pick.
// Ports:
//   remaining (in,  W) : cents still owed
//   code      (out, 2) : coin code to present
//   value     (out, W) : value of that coin in cents
// With CHANGE_DOLLAR_COIN_EN defined, dollars are tried first; otherwise
// large amounts are paid in quarters. Below 10 cents the pick is always
// a nickel; the caller never asks for a coin when fewer than 5 cents remain.
module coin_select
  import vend_pkg::*;
#(
  parameter int W = CREDIT_W_DEF
) (
  input  logic [W-1:0] remaining,
  output coin_t        code,
  output logic [W-1:0] value
);

  logic dollar_ok;

`ifdef CHANGE_DOLLAR_COIN_EN
  assign dollar_ok = (remaining >= W'(COIN_VAL_DOLLAR));
`else
  assign dollar_ok = 1'b0;
`endif

  always_comb begin
    code  = COIN_NICKEL;
    value = W'(COIN_VAL_NICKEL);
    if (dollar_ok) begin
      code  = COIN_DOLLAR;
      value = W'(COIN_VAL_DOLLAR);
    end else if (remaining >= W'(COIN_VAL_QUARTER)) begin
      code  = COIN_QUARTER;
      value = W'(COIN_VAL_QUARTER);
    end else if (remaining >= W'(COIN_VAL_DIME)) begin
      code  = COIN_DIME;
      value = W'(COIN_VAL_DIME);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: computes credit - cost on a start pulse and pays the
// difference out as a greedy coin sequence over a valid/ready handshake.
// Ports:
//   clk  (in) : system clock, rising edge
//   rst  (in) : asynchronous active-high reset
//   bus  (change_dispenser_if.slave) : start/credit/cost request,
//        coin_valid/coin_type/coin_ready handshake, busy/done/insufficient
//        status and change_total.
// Optional feature: CHANGE_DOLLAR_COIN_EN enables the 100-cent coin
// (handled inside coin_select).
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  change_dispenser_if.slave    bus
);

  localparam logic [CREDIT_W-1:0] MIN_COIN = CREDIT_W'(COIN_VAL_NICKEL);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] remaining_reg, remaining_next;
  logic [CREDIT_W-1:0] change_total_reg, change_total_next;
  logic [CREDIT_W:0]   diff;
  logic [CREDIT_W-1:0] after_coin;
  coin_t               pick_code;
  logic [CREDIT_W-1:0] pick_value;

  coin_select #(.W(CREDIT_W)) u_coin_select (
    .remaining (remaining_reg),
    .code      (pick_code),
    .value     (pick_value)
  );

  // One extra bit so that credit < cost shows up as a borrow in the MSB.
  assign diff = {1'b0, bus.credit} - {1'b0, bus.cost};

  // The greedy pick never exceeds remaining while in DISPENSE (>= 5 there),
  // so this subtraction cannot wrap.
  assign after_coin = remaining_reg - pick_value;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      remaining_reg    <= '0;
      change_total_reg <= '0;
    end else begin
      state_reg        <= state_next;
      remaining_reg    <= remaining_next;
      change_total_reg <= change_total_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next        = state_reg;
    remaining_next    = remaining_reg;
    change_total_next = change_total_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          if (diff[CREDIT_W]) begin
            state_next = ST_ERROR;
          end else begin
            remaining_next    = diff[CREDIT_W-1:0];
            change_total_next = diff[CREDIT_W-1:0];
            state_next = (diff[CREDIT_W-1:0] >= MIN_COIN) ? ST_DISPENSE : ST_DONE;
          end
        end
      end
      ST_DISPENSE: begin
        // coin_valid is always high here, so coin_ready alone completes it.
        if (bus.coin_ready) begin
          remaining_next = after_coin;
          if (after_coin < MIN_COIN) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state/remaining only.
  always_comb begin
    bus.coin_valid   = 1'b0;
    bus.coin_type    = 2'd0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.insufficient = 1'b0;
    case (state_reg)
      ST_DISPENSE: begin
        bus.coin_valid = 1'b1;
        bus.coin_type  = pick_code;
        bus.busy       = 1'b1;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      ST_ERROR: begin
        bus.insufficient = 1'b1;
        bus.busy         = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.change_total = change_total_reg;

endmodule
